// File: rtl/spi_board_router.sv
// Routes one SPI master onto one of four boards (three chip selects each), gated by
// debounced board-present flags, with a chip-select collision fault and a drop counter.
`timescale 1ns/1ps
module spi_board_router #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] qsys_csn,
  input  logic        qsys_sclk,
  input  logic        qsys_mosi,
  output logic        qsys_miso,
  input  logic [3:0]  live,
  input  logic [3:0]  miso,
  output logic [3:0]  sclk,
  output logic [3:0]  mosi,
  output logic [11:0] csn,
  output logic [3:0]  live_stat,
  output logic        fault,
  output logic [7:0]  drop_cnt,
  input  logic        fault_clr
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_END, FAULT} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_live_s1, r_live_s2, r_miso_s1, r_miso_s2;
  logic [3:0]  w_live_stat;
  logic [3:0]  r_sel, w_sel_next, w_idx;
  logic [1:0]  r_board, w_board_next, w_board;
  logic        r_armed;
  logic [11:0] w_low, r_csn, w_csn_next;
  logic [3:0]  r_sclk, r_mosi, w_sclk_next, w_mosi_next;
  logic        r_qsys_miso, w_qsys_miso_next;
  logic        r_fault, w_drop_inc;
  logic [7:0]  r_drop_cnt;
  logic        w_any_low, w_multi_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live_s1 <= '0;
      r_live_s2 <= '0;
      r_miso_s1 <= '0;
      r_miso_s2 <= '0;
    end else begin
      r_live_s1 <= live;
      r_live_s2 <= r_live_s1;
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Per-board debounce: the flag flips only after a full run of disagreeing samples.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CW-1:0] r_db_cnt;
      logic          r_stat;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_db_cnt <= '0;
          r_stat   <= 1'b0;
        end else if (r_live_s2[gi] != r_stat) begin
          if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt <= '0;
            r_stat   <= r_live_s2[gi];
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
      assign w_live_stat[gi] = r_stat;
    end
  endgenerate

  always_comb begin
    w_low       = ~qsys_csn;
    w_any_low   = |w_low;
    w_multi_low = |(w_low & (w_low - 12'd1));
    w_idx       = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_low[i]) w_idx = 4'(i);
    end
    if (w_idx < 4'd3)      w_board = 2'd0;
    else if (w_idx < 4'd6) w_board = 2'd1;
    else if (w_idx < 4'd9) w_board = 2'd2;
    else                   w_board = 2'd3;
  end

  // r_armed blocks acceptance after reset until the master has released every select.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_board_next = r_board;
    w_drop_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_multi_low) begin
          w_state_next = FAULT;
        end else if (w_any_low && r_armed) begin
          if (w_live_stat[w_board]) begin
            w_state_next = ACTIVE;
            w_sel_next   = w_idx;
            w_board_next = w_board;
          end else begin
            w_state_next = WAIT_END;
            w_drop_inc   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (w_multi_low) begin
          w_state_next = FAULT;
        end else if (!w_live_stat[r_board]) begin
          w_state_next = WAIT_END;
          w_drop_inc   = 1'b1;
        end else if (qsys_csn[r_sel]) begin
          w_state_next = IDLE;
        end
      end
      WAIT_END: if (!w_any_low) w_state_next = IDLE;
      FAULT:    if (fault_clr && !w_any_low) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_csn_next       = '1;
    w_sclk_next      = '0;
    w_mosi_next      = '0;
    w_qsys_miso_next = 1'b0;
    if (w_state_next == ACTIVE) begin
      w_csn_next[w_sel_next]    = qsys_csn[w_sel_next];
      w_sclk_next[w_board_next] = qsys_sclk;
      w_mosi_next[w_board_next] = qsys_mosi;
      w_qsys_miso_next          = r_miso_s2[w_board_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_board     <= '0;
      r_armed     <= 1'b0;
      r_csn       <= '1;
      r_sclk      <= '0;
      r_mosi      <= '0;
      r_qsys_miso <= 1'b0;
      r_fault     <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_board     <= w_board_next;
      if (!w_any_low) r_armed <= 1'b1;
      r_csn       <= w_csn_next;
      r_sclk      <= w_sclk_next;
      r_mosi      <= w_mosi_next;
      r_qsys_miso <= w_qsys_miso_next;
      r_fault     <= (w_state_next == FAULT);
      if (fault_clr)
        r_drop_cnt <= '0;
      else if (w_drop_inc && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign csn       = r_csn;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign qsys_miso = r_qsys_miso;
  assign live_stat = w_live_stat;
  assign fault     = r_fault;
  assign drop_cnt  = r_drop_cnt;
endmodule
